// File: rtl/dm_access_ctrl.sv
// Load/store controller between the CPU datapath and a word-wide data memory.
// Optional DM_MISALIGN_CHECK_EN: misaligned LW/SW/LH/LHU/SH skip DM and respond with err=1.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DM_WORDS_LOG2 = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    input  logic [31:0]       dm_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    if (ADDR_W < DM_WORDS_LOG2 + 2) begin : g_cfg_check
        $error("ADDR_W is too narrow to hold the DM word index");
    end

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        misaligned;
    logic        accept;
    logic        op_is_load;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merge_val;

`ifdef DM_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign ready      = (state == IDLE);
    assign done       = (state == RESP);
    assign dm_we      = (state == WR);
    assign accept     = (state == IDLE) && req;
    assign op_is_load = (op_q <= OP_LHU);

    // Lane extraction from the word the DM returns during RD.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = dm_rdata[7:0];
            2'd1:    byte_sel = dm_rdata[15:8];
            2'd2:    byte_sel = dm_rdata[23:16];
            default: byte_sel = dm_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

        case (op_q)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            default: load_val = dm_rdata;
        endcase

        merge_val = dm_rdata;
        if (op_q == OP_SB) begin
            case (lane_q)
                2'd0:    merge_val[7:0]   = wdata_q[7:0];
                2'd1:    merge_val[15:8]  = wdata_q[7:0];
                2'd2:    merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merge_val[31:16] = wdata_q;
        end else begin
            merge_val[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned)      state_nxt = RESP;
                    else if (op == OP_SW) state_nxt = WR;
                    else                 state_nxt = RD;
                end
            end
            RD:      state_nxt = op_is_load ? RESP : WR;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // dm_addr/dm_wdata are registered ahead of RD/WR so they are stable for the whole DM cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            lane_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            if (accept) begin
                op_q    <= op;
                lane_q  <= addr[1:0];
                wdata_q <= wdata[15:0];
                rdata   <= '0;
                err     <= misaligned;
                if (!misaligned) begin
                    dm_addr <= {addr[ADDR_W-1:2], 2'b00};
                    if (op == OP_SW) dm_wdata <= wdata;
                end
            end
            if (state == RD) begin
                if (op_is_load) rdata    <= load_val;
                else            dm_wdata <= merge_val;
            end
        end
    end

endmodule
